// File: rtl/mem_lsu_pkg.sv
// Shared definitions for the memory-access stage: funct3 codes, FSM encoding and
// access-size helpers for byte enables, store lane replication and alignment.
package mem_lsu_pkg;

  localparam logic [2:0] INST_LB  = 3'b000;
  localparam logic [2:0] INST_LH  = 3'b001;
  localparam logic [2:0] INST_LW  = 3'b010;
  localparam logic [2:0] INST_LBU = 3'b100;
  localparam logic [2:0] INST_LHU = 3'b101;
  localparam logic [2:0] INST_SB  = 3'b000;
  localparam logic [2:0] INST_SH  = 3'b001;
  localparam logic [2:0] INST_SW  = 3'b010;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StReq  = 2'b01,
    StResp = 2'b10,
    StDone = 2'b11
  } lsu_state_e;

  function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
    if (is_store) return f3 inside {INST_SB, INST_SH, INST_SW};
    return f3 inside {INST_LB, INST_LH, INST_LW, INST_LBU, INST_LHU};
  endfunction

  // funct3[1:0] encodes the access size for both loads and stores.
  function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b00:   return 4'b0001 << a;
      2'b01:   return 4'b0011 << {a[1], 1'b0};
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] d);
    case (f3[1:0])
      2'b00:   return {4{d[7:0]}};
      2'b01:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b01:   return a[0];
      2'b10:   return a != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_lsu_load_ext.sv
// Load data extraction: selects the addressed byte/half of a bus word and
// sign- or zero-extends it according to funct3.
module mem_lsu_load_ext
  import mem_lsu_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = rdata_i[{addr_i, 3'b000} +: 8];
    w_half = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (funct3_i)
      INST_LB:  data_o = {{24{w_byte[7]}}, w_byte};
      INST_LBU: data_o = {24'b0, w_byte};
      INST_LH:  data_o = {{16{w_half[15]}}, w_half};
      INST_LHU: data_o = {16'b0, w_half};
      default:  data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// Memory-access stage: runs a req/gnt/rvalid bus transaction, holds the pipeline
// while it is outstanding, and registers the writeback result. Option: MEM_MISALIGN_TRAP_EN.
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int unsigned RESP_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_data_i,
  input  logic        mem_we_i,
  input  logic        mem_re_i,
  input  logic [4:0]  rd_addr_i,
  input  logic [31:0] rd_data_i,
  input  logic        rd_wen_i,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  output logic [3:0]  bus_be_o,
  input  logic        bus_gnt_i,
  input  logic        bus_rvalid_i,
  input  logic [31:0] bus_rdata_i,
  output logic [4:0]  rd_addr_o,
  output logic [31:0] rd_data_o,
  output logic        rd_wen_o,
  output logic        hold_flag_o,
  output logic        bus_err_o
`ifdef MEM_MISALIGN_TRAP_EN
  ,
  output logic        misalign_o,
  output logic [31:0] misalign_addr_o
`endif
);

  localparam int unsigned CntW = $clog2(RESP_TIMEOUT + 2);

  lsu_state_e      r_state, w_state_nxt;
  logic [31:0]     r_addr, r_wdata;
  logic [3:0]      r_be;
  logic [2:0]      r_funct3;
  logic [4:0]      r_rd_addr;
  logic            r_we;
  logic [CntW-1:0] r_cnt, w_cnt_inc;
  logic [4:0]      r_wb_addr;
  logic [31:0]     r_wb_data;
  logic            r_wb_wen, r_bus_err;
  logic            w_access, w_legal, w_misalign, w_start, w_timeout, w_in_req;
  logic [31:0]     w_load_data;

  assign w_access  = mem_we_i | mem_re_i;
  assign w_legal   = f3_legal(mem_we_i, funct3_i);
`ifdef MEM_MISALIGN_TRAP_EN
  assign w_misalign = is_misaligned(funct3_i, mem_addr_i[1:0]);
`else
  assign w_misalign = 1'b0;
`endif
  assign w_start   = (r_state == StIdle) & w_access & w_legal & ~w_misalign;
  assign w_in_req  = (r_state == StReq);
  assign w_cnt_inc = r_cnt + CntW'(1);
  // Abort once RESP_TIMEOUT cycles have been spent across REQ and RESP.
  assign w_timeout = (RESP_TIMEOUT != 0) && (w_cnt_inc == CntW'(RESP_TIMEOUT));

  mem_lsu_load_ext u_load_ext (
    .rdata_i  (bus_rdata_i),
    .addr_i   (r_addr[1:0]),
    .funct3_i (r_funct3),
    .data_o   (w_load_data)
  );

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle: if (w_start) w_state_nxt = StReq;
      StReq: begin
        if (bus_gnt_i)      w_state_nxt = r_we ? StDone : StResp;
        else if (w_timeout) w_state_nxt = StDone;
      end
      StResp: if (bus_rvalid_i || w_timeout) w_state_nxt = StDone;
      StDone: w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= StIdle;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_be      <= '0;
      r_funct3  <= '0;
      r_rd_addr <= '0;
      r_we      <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start) begin
        r_addr    <= mem_addr_i;
        r_wdata   <= store_data(funct3_i, mem_data_i);
        r_be      <= byte_en(funct3_i, mem_addr_i[1:0]);
        r_funct3  <= funct3_i;
        r_rd_addr <= rd_addr_i;
        r_we      <= mem_we_i;
        r_cnt     <= '0;
      end else if (r_state == StReq || r_state == StResp) begin
        r_cnt <= w_cnt_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wb_addr <= '0;
      r_wb_data <= '0;
      r_wb_wen  <= 1'b0;
      r_bus_err <= 1'b0;
    end else begin
      r_wb_wen  <= 1'b0;
      r_bus_err <= 1'b0;
      case (r_state)
        StIdle: begin
          if (!w_access) begin
            r_wb_addr <= rd_addr_i;
            r_wb_data <= rd_data_i;
            r_wb_wen  <= rd_wen_i;
          end
        end
        StReq: begin
          if (!bus_gnt_i && w_timeout) begin
            r_bus_err <= 1'b1;
            if (!r_we) begin
              r_wb_addr <= r_rd_addr;
              r_wb_data <= '0;
              r_wb_wen  <= 1'b1;
            end
          end
        end
        StResp: begin
          if (bus_rvalid_i) begin
            r_wb_addr <= r_rd_addr;
            r_wb_data <= w_load_data;
            r_wb_wen  <= 1'b1;
          end else if (w_timeout) begin
            r_bus_err <= 1'b1;
            r_wb_addr <= r_rd_addr;
            r_wb_data <= '0;
            r_wb_wen  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef MEM_MISALIGN_TRAP_EN
  logic        r_misalign;
  logic [31:0] r_misalign_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_misalign      <= 1'b0;
      r_misalign_addr <= '0;
    end else begin
      r_misalign <= 1'b0;
      if (r_state == StIdle && w_access && w_legal && w_misalign) begin
        r_misalign      <= 1'b1;
        r_misalign_addr <= mem_addr_i;
      end
    end
  end

  assign misalign_o      = r_misalign;
  assign misalign_addr_o = r_misalign_addr;
`endif

  // Bus fields are only driven while the request is live.
  assign bus_req_o   = w_in_req;
  assign bus_we_o    = w_in_req & r_we;
  assign bus_addr_o  = w_in_req ? {r_addr[31:2], 2'b00} : '0;
  assign bus_wdata_o = w_in_req ? r_wdata : '0;
  assign bus_be_o    = w_in_req ? r_be : '0;

  assign rd_addr_o   = r_wb_addr;
  assign rd_data_o   = r_wb_data;
  assign rd_wen_o    = r_wb_wen;
  assign bus_err_o   = r_bus_err;
  assign hold_flag_o = w_start | (r_state == StReq) | (r_state == StResp);

endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
- Memory-access stage. Consumes the ex_mem load/store request: address, store data, mem_we, mem_re, funct3, rd_*.
- Runs a request/grant/response transaction on the data bus.
- Holds the pipeline through control while the transaction is outstanding.
- Returns the registered writeback result (load data or passed-through ALU result) to mem_wb.

Parameters:
- RESP_TIMEOUT, 255: max cycles waiting in REQ or RESP before abort; 0 disables timeout.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- funct3_i  in  3  access size/sign from instruction
- mem_addr_i  in  32  byte address from ex_mem
- mem_data_i  in  32  store data, low-aligned
- mem_we_i  in  1  store request
- mem_re_i  in  1  load request
- rd_addr_i  in  5  destination register
- rd_data_i  in  32  ALU result
- rd_wen_i  in  1  writeback enable for non-memory ops
- bus_req_o  out  1  bus request
- bus_we_o  out  1  1 = write
- bus_addr_o  out  32  word-aligned address {addr[31:2],2'b00}
- bus_wdata_o  out  32  lane-replicated store data
- bus_be_o  out  4  byte enables
- bus_gnt_i  in  1  request accepted
- bus_rvalid_i  in  1  read data valid
- bus_rdata_i  in  32  read data
- rd_addr_o  out  5  registered writeback address
- rd_data_o  out  32  registered writeback data
- rd_wen_o  out  1  registered writeback enable
- hold_flag_o  out  1  to control: freeze upstream stages
- bus_err_o  out  1  one-cycle pulse on timeout abort

Behaviour:
- Reset: all outputs 0, FSM to IDLE, timeout counter 0. Reset mid-transaction drops bus_req_o immediately; the in-flight access is lost.
- FSM states: IDLE, REQ, RESP, DONE.
- IDLE, no access (mem_re_i=mem_we_i=0): rd_* inputs are registered to rd_*_o at the next edge; 1-cycle latency.
- IDLE, access with legal funct3: latch addr, be, wdata, funct3 and rd_addr; go to REQ. hold_flag_o=1 combinationally this cycle. rd_wen_o=0 at the next edge (bubble).
- Illegal funct3: legal loads are 000/001/010/100/101; legal stores are 000/001/010. An access with any other funct3 produces no bus activity and a one-cycle bubble (rd_wen_o=0). The FSM stays in IDLE.
- If mem_re_i and mem_we_i are both 1, the store takes priority.
- REQ: bus_req_o=1 with latched fields held stable until bus_gnt_i.
  - Grant on a store: go to DONE.
  - Grant on a load: go to RESP.
- RESP: wait for bus_rvalid_i. On rvalid, extract and extend bus_rdata_i by addr[1:0] and funct3 (LB/LBU byte, LH/LHU half, LW word), latch the result, go to DONE. An rvalid arriving in the same cycle as the grant is not accepted.
- DONE: hold_flag_o=0 and the pipeline advances this cycle.
  - Load: rd_data_o/rd_addr_o updated, rd_wen_o=1 for one cycle.
  - Store: rd_wen_o=0.
  - Unconditional return to IDLE. Inputs are ignored this cycle, so the still-presented instruction is not re-issued.
- hold_flag_o = (IDLE & access & legal) | REQ | RESP.
- Byte enables:
  - SB: 0001<<addr[1:0]
  - SH: 0011<<{addr[1],1'b0}
  - SW: 1111
- Store data replication:
  - SB: {4{d[7:0]}}
  - SH: {2{d[15:0]}}
  - SW: d
- Misalignment without the optional feature: low address bits below the access size are ignored (LH uses addr[1] only; LW ignores addr[1:0]).
- Timeout: the counter clears on entering REQ and increments each cycle in REQ/RESP. When it reaches RESP_TIMEOUT (nonzero):
  - bus_req_o drops and the FSM goes to DONE.
  - bus_err_o pulses 1 cycle in DONE.
  - A load writes 0 with rd_wen_o=1.

Optional Feature:
- MEM_MISALIGN_TRAP_EN
- Defined: adds ports misalign_o (1) and misalign_addr_o (32). A misaligned LH/LHU/SH (addr[0]=1) or LW/SW (addr[1:0]!=0) in IDLE:
  - issues no bus request and raises no hold;
  - registers misalign_o=1 for one cycle and misalign_addr_o = the byte address;
  - sets rd_wen_o=0.
- Undefined: ports absent; misaligned accesses behave per the truncation rule above.

Decomposition:
- defines.v gets INST_LB/LH/LW/LBU/LHU/SB/SH/SW funct3 codes and the FSM state encodings (2-bit).
- Sub-module load_ext: combinational byte/half selection and sign/zero extension (inputs rdata, addr[1:0], funct3; output 32-bit). Reused by any future cache path.

Test Plan:
- Non-memory: rd_data_i=0x1234, rd_addr_i=5, rd_wen_i=1 -> next cycle rd_data_o=0x1234, rd_wen_o=1, hold_flag_o never 1.
- LB, addr 0x103, gnt after 2 cycles, rvalid 1 cycle later with rdata 0x80FF_0000 -> bus_addr_o=0x100, bus_be_o=1000, hold high 4 cycles, rd_data_o=0xFFFF_FF80, rd_wen_o pulse.
- SH, addr 0x202, data 0x0000_ABCD, gnt same cycle -> bus_wdata_o=0xABCD_ABCD, bus_be_o=1100, bus_we_o=1, rd_wen_o stays 0, next instruction issues after DONE.
- LHU, addr 0x2, rdata 0xF00D_0000 -> rd_data_o=0x0000_F00D. LH, addr 0x0, rdata 0x0000_8001 -> rd_data_o=0xFFFF_8001.
- RESP_TIMEOUT=4, LW, gnt given, rvalid never -> bus_err_o pulse, rd_data_o=0, FSM back to IDLE, hold released.
- rst_n low while in RESP -> bus_req_o, hold_flag_o, rd_wen_o 0 immediately. With MEM_MISALIGN_TRAP_EN: LW addr 0x6 -> misalign_o pulse, misalign_addr_o=0x6, no bus_req_o.
